// File: rtl/vx_barrier_unit_if.sv
// Barrier request / release bundle for vx_barrier_unit.
// The master drives barrier requests and the slave (the barrier unit) drives
// the stall, release and error status back.
interface vx_barrier_unit_if #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4
);
  localparam int NB_BITS = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;
  localparam int NW_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

  logic                 bar_valid;
  logic [NW_BITS-1:0]   bar_wid;
  logic [NB_BITS-1:0]   bar_id;
  logic [NW_BITS-1:0]   bar_size_m1;
  logic [NUM_WARPS-1:0] stalled_warps;
  logic                 release_valid;
  logic [NUM_WARPS-1:0] release_mask;
  logic                 bar_error;

  modport master (
    output bar_valid, bar_wid, bar_id, bar_size_m1,
    input  stalled_warps, release_valid, release_mask, bar_error
  );

  modport slave (
    input  bar_valid, bar_wid, bar_id, bar_size_m1,
    output stalled_warps, release_valid, release_mask, bar_error
  );
endinterface

// File: rtl/vx_barrier_unit.sv
// Warp barrier unit: tracks per-slot arrival masks/counts, stalls arriving
// warps until the slot's participant count is reached, then emits a single
// cycle release pulse with the freed warp mask. Protocol errors are sticky.
// Optional feature: define BAR_PERF_EN to add the 64-bit perf_stall_cycles
// counter (edges on which any warp is stalled).
module vx_barrier_unit #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  vx_barrier_unit_if.slave     bus
`ifdef BAR_PERF_EN
  ,
  output logic [63:0]          perf_stall_cycles
`endif
);

  localparam int NB_BITS = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;
  localparam int NW_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int CW      = NW_BITS + 1;

  logic [NUM_WARPS-1:0] mask_q  [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] mask_d  [NUM_BARRIERS];
  logic [CW-1:0]        count_q [NUM_BARRIERS];
  logic [CW-1:0]        count_d [NUM_BARRIERS];
  logic [NW_BITS-1:0]   size_q  [NUM_BARRIERS];
  logic [NW_BITS-1:0]   size_d  [NUM_BARRIERS];

  logic [NUM_WARPS-1:0] stalled_q, stalled_d;
  logic                 rel_valid_q, rel_valid_d;
  logic [NUM_WARPS-1:0] rel_mask_q, rel_mask_d;
  logic                 err_q, err_d;

  logic [NUM_WARPS-1:0] any_mask;
  logic [NUM_WARPS-1:0] wid_bit;
  logic                 slot_idle;
  logic [NW_BITS-1:0]   size_eff;
  logic [CW-1:0]        next_cnt;

  // Next-state decode for the single request accepted this cycle
  always_comb begin
    mask_d      = mask_q;
    count_d     = count_q;
    size_d      = size_q;
    rel_valid_d = 1'b0;
    rel_mask_d  = '0;
    err_d       = err_q;
    any_mask    = '0;
    wid_bit     = '0;
    slot_idle   = 1'b0;
    size_eff    = '0;
    next_cnt    = '0;
    stalled_d   = '0;

    for (int b = 0; b < NUM_BARRIERS; b++) begin
      any_mask = any_mask | mask_q[b];
    end
    wid_bit = NUM_WARPS'(1) << bus.bar_wid;

    if (bus.bar_valid) begin
      if ((any_mask & wid_bit) != '0) begin
        // A warp already parked at a barrier cannot arrive again: flag only.
        err_d = 1'b1;
      end else begin
        slot_idle = (count_q[bus.bar_id] == '0);
        // A busy slot keeps the size latched by its first arrival.
        size_eff  = slot_idle ? bus.bar_size_m1 : size_q[bus.bar_id];
        next_cnt  = count_q[bus.bar_id] + CW'(1);
        if (!slot_idle && (bus.bar_size_m1 != size_q[bus.bar_id])) begin
          err_d = 1'b1;
        end
        if (slot_idle) begin
          size_d[bus.bar_id] = bus.bar_size_m1;
        end
        if (next_cnt == (CW'(size_eff) + CW'(1))) begin
          rel_valid_d         = 1'b1;
          rel_mask_d          = mask_q[bus.bar_id] | wid_bit;
          mask_d[bus.bar_id]  = '0;
          count_d[bus.bar_id] = '0;
        end else begin
          mask_d[bus.bar_id]  = mask_q[bus.bar_id] | wid_bit;
          count_d[bus.bar_id] = next_cnt;
        end
      end
    end

    // Built from the post-edge masks so released warps drop out immediately.
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      stalled_d = stalled_d | mask_d[b];
    end
  end

  // Slot state and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        mask_q[b]  <= '0;
        count_q[b] <= '0;
        size_q[b]  <= '0;
      end
      stalled_q   <= '0;
      rel_valid_q <= 1'b0;
      rel_mask_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      mask_q      <= mask_d;
      count_q     <= count_d;
      size_q      <= size_d;
      stalled_q   <= stalled_d;
      rel_valid_q <= rel_valid_d;
      rel_mask_q  <= rel_mask_d;
      err_q       <= err_d;
    end
  end

  assign bus.stalled_warps = stalled_q;
  assign bus.release_valid = rel_valid_q;
  assign bus.release_mask  = rel_mask_q;
  assign bus.bar_error     = err_q;

`ifdef BAR_PERF_EN
  logic [63:0] perf_q, perf_d;

  // Count edges on which the registered stall vector is non-empty
  always_comb begin
    perf_d = perf_q + ((stalled_q != '0) ? 64'd1 : 64'd0);
  end

  // Performance counter register, wraps naturally at 2^64
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stall_cycles = perf_q;
`endif

endmodule

// File: doc/vx_barrier_unit.md
VX_BARRIER_UNIT -- requirements
Module: VX_barrier_unit

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4, meaning the number of warps tracked (power of 2, 2..32).
REQ-002 SHALL have parameter NUM_BARRIERS, default 4, meaning the number of barrier slots (power of 2, 1..16); NB_BITS=max(1,log2(NUM_BARRIERS)) and NW_BITS=max(1,log2(NUM_WARPS)).
REQ-003 SHALL have port clk, input, 1 bit: the single clock, all state on rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port bar_valid, input, 1 bit: barrier request strobe, decoded from the barrier record's valid field.
REQ-006 SHALL have port bar_wid, input, NW_BITS: the issuing warp.
REQ-007 SHALL have port bar_id, input, NB_BITS: the barrier slot.
REQ-008 SHALL have port bar_size_m1, input, NW_BITS: participant count minus one.
REQ-009 SHALL have port stalled_warps, output, NUM_WARPS: warps currently held at any barrier.
REQ-010 SHALL have port release_valid, output, 1 bit: one-cycle release pulse.
REQ-011 SHALL have port release_mask, output, NUM_WARPS: warps freed by this release.
REQ-012 SHALL have port bar_error, output, 1 bit: sticky protocol-error flag.
REQ-013 SHALL have port perf_stall_cycles, output, 64 bits: present only with BAR_PERF_EN.

Function
REQ-014 SHALL keep, per slot, a wait mask (NUM_WARPS), an arrival count (NW_BITS+1), and a latched size_m1 (NW_BITS).
REQ-015 SHALL accept at most one request per cycle; the request is always accepted (no ready).
REQ-016 SHALL treat a slot as idle when its count is 0; the first arrival latches bar_size_m1 into the slot.
REQ-017 SHALL, on a non-final arrival, set bit bar_wid in the slot mask and increment count, with the stall visible on stalled_warps the next cycle.
REQ-018 SHALL, on the final arrival (count+1 == size_m1+1), register release_valid=1 and release_mask=slot mask OR the bit for bar_wid, both visible the next cycle for exactly one cycle.
REQ-019 SHALL, on the final arrival, clear the slot mask and count in the same edge.
REQ-020 SHALL, when bar_size_m1==0 on an idle slot, release immediately (release_mask = the bit for bar_wid only) with no stall.
REQ-021 SHALL drive stalled_warps as the bitwise OR of all slot masks, registered.
REQ-022 SHALL not let a warp that was released at edge N appear in stalled_warps after edge N.
REQ-023 SHALL treat as an error a request from a warp already set in any slot mask: set bar_error and leave all state unchanged.
REQ-024 SHALL treat as an error a request whose bar_size_m1 differs from the latched size_m1 of a non-idle slot: set bar_error and still process the arrival using the latched size.
REQ-025 SHALL hold bar_error at 1 until reset.
REQ-026 SHALL deassert release_valid, and drive release_mask to 0, in cycles with no release.

Reset
REQ-027 SHALL, on reset_n low and regardless of clk, clear all slot masks, counts and sizes, stalled_warps, release_valid, release_mask, bar_error and perf_stall_cycles to 0.
REQ-028 SHALL, on reset mid-barrier, drop all waiting warps without emitting a release pulse.
REQ-029 SHALL ignore bar_valid in the first edge after reset_n deasserts only if it coincides with that deassertion; the following edge processes requests normally.

Configuration
REQ-030 SHALL, with BAR_PERF_EN defined, provide perf_stall_cycles, which increments by 1 on each edge where stalled_warps != 0 and wraps modulo 2^64.
REQ-031 SHALL, without BAR_PERF_EN, omit the perf_stall_cycles port and its counter entirely, with all other behaviour identical.

Verification
REQ-032 SHALL cover: NUM_WARPS=4; bar_id=1, size_m1=2; warps 0 and 2 arrive on consecutive cycles -> stalled_warps=0101; warp 3 arrives -> next cycle release_valid=1, release_mask=1101, and stalled_warps=0000 after.
REQ-033 SHALL cover: size_m1=0 from warp 1 -> release_mask=0010 the next cycle, and stalled_warps stays 0000.
REQ-034 SHALL cover: warp 0 waiting on slot 0 requests slot 2 -> bar_error=1, and slot 2 stays idle.
REQ-035 SHALL cover: slot 0 latched size_m1=1 (warp 0) and warp 1 arrives with size_m1=3 -> bar_error=1 and release_mask=0011.
REQ-036 SHALL cover: two slots waiting (masks 0001 and 0100) and reset_n pulsed low mid-cycle -> all outputs 0 immediately, and no release pulse follows.
REQ-037 SHALL cover: with BAR_PERF_EN, warp 0 stalled for 5 cycles then released -> perf_stall_cycles=5.
